// File: rtl/hazard_controller.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: RAW detection, bubble/flush control, event counters.
// Define FORWARDING_EN to add EX-stage forwarding selects and reduce stalls to load-use only.
module hazard_controller #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned RF_BYPASS = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_REGWRITE,
    input  logic             EX_MEMREAD,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_REGWRITE,
    input  logic [4:0]       WB_RD,
    input  logic             WB_REGWRITE,
    input  logic             BRANCH_TAKEN,
`ifdef FORWARDING_EN
    input  logic [4:0]       EX_RS1,
    input  logic [4:0]       EX_RS2,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
`endif
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IDEX_BUBBLE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic             STALL_ERR
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]       run_q, run_d;
    logic             err_q, err_d;
    logic             hazard, taken, stall;

    function automatic logic src_match(input logic [4:0] rs);
`ifdef FORWARDING_EN
        return (rs != 5'd0) && EX_MEMREAD && EX_REGWRITE && (EX_RD == rs);
`else
        return (rs != 5'd0) &&
               ((EX_REGWRITE && (EX_RD == rs)) ||
                (MEM_REGWRITE && (MEM_RD == rs)) ||
                ((RF_BYPASS == 0) && WB_REGWRITE && (WB_RD == rs)));
`endif
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (MEM_REGWRITE && (MEM_RD != 5'd0) && (MEM_RD == rs))
            return 2'b10;
        else if (WB_REGWRITE && (WB_RD != 5'd0) && (WB_RD == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign FWD_A = fwd_sel(EX_RS1);
    assign FWD_B = fwd_sel(EX_RS2);
`endif

    assign hazard = (ID_USES_RS1 && src_match(ID_RS1)) || (ID_USES_RS2 && src_match(ID_RS2));
    // EX/ME holds a bubble in FLUSH, so a branch indication there is stale
    assign taken  = BRANCH_TAKEN && (state_q != ST_FLUSH);
    assign stall  = hazard && !taken;

    always_comb begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IDEX_BUBBLE = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        if (RESET) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
        end else if (taken) begin
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
        end else if (stall) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
        end
    end

    always_comb begin
        state_d     = taken ? ST_FLUSH : (hazard ? ST_STALL : ST_RUN);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = '0;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (taken && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (stall)
            run_d = (run_q == '1) ? run_q : run_q + 8'd1;
        err_d = err_q || (run_d >= 8'(MAX_STALL));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
    assign STALL_ERR = err_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a reference model predicts every cycle's outputs.
// Also covers the FORWARDING_EN build when that macro is defined.
module tb_hazard_controller;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_STALL = 4;
    localparam int unsigned RF_BYPASS = 1;

    logic             CLK, RESET;
    logic [4:0]       ID_RS1, ID_RS2, EX_RD, MEM_RD, WB_RD;
    logic             ID_USES_RS1, ID_USES_RS2, EX_REGWRITE, EX_MEMREAD;
    logic             MEM_REGWRITE, WB_REGWRITE, BRANCH_TAKEN;
    logic             PC_WRITE, IFID_WRITE, IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
    logic             STALL_ERR;
`ifdef FORWARDING_EN
    logic [4:0]       EX_RS1, EX_RS2;
    logic [1:0]       FWD_A, FWD_B;
`endif

    hazard_controller #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL), .RF_BYPASS(RF_BYPASS)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD),
        .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE), .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
        .BRANCH_TAKEN(BRANCH_TAKEN),
`ifdef FORWARDING_EN
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .FWD_A(FWD_A), .FWD_B(FWD_B),
`endif
        .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .IDEX_BUBBLE(IDEX_BUBBLE),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_FLUSH(EXMEM_FLUSH),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .STALL_ERR(STALL_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]       ctrl;
        logic [3:0]       fwd;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_sc, m_fc;
    int unsigned      m_run;
    logic             m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_src(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
`ifdef FORWARDING_EN
        return EX_MEMREAD && EX_REGWRITE && EX_RD == rs;
`else
        if (EX_REGWRITE && EX_RD == rs) return 1'b1;
        if (MEM_REGWRITE && MEM_RD == rs) return 1'b1;
        if (RF_BYPASS == 0 && WB_REGWRITE && WB_RD == rs) return 1'b1;
        return 1'b0;
`endif
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (MEM_REGWRITE && MEM_RD == rs && rs != 5'd0) return 2'b10;
        if (WB_REGWRITE && WB_RD == rs && rs != 5'd0) return 2'b01;
        return 2'b00;
    endfunction
`endif

    // Inputs are set at the falling edge; expectations come from the model, then the model steps.
    task automatic cycle();
        exp_t e, d;
        logic hz, tk, st;
        #1;
        hz = (ID_USES_RS1 && m_src(ID_RS1)) || (ID_USES_RS2 && m_src(ID_RS2));
        tk = BRANCH_TAKEN && (m_state != 2'd2);
        st = hz && !tk;
        if (RESET)   e.ctrl = 6'b000111;
        else if (tk) e.ctrl = 6'b110111;
        else if (st) e.ctrl = 6'b001000;
        else         e.ctrl = 6'b110000;
        e.fwd = 4'b0000;
`ifdef FORWARDING_EN
        e.fwd = {m_fwd(EX_RS1), m_fwd(EX_RS2)};
`endif
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.err = m_err;
        sb.push_back(e);

        d = sb.pop_front();
        check("ctrl", {26'd0, PC_WRITE, IFID_WRITE, IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH},
              {26'd0, d.ctrl});
`ifdef FORWARDING_EN
        check("fwd", {28'd0, FWD_A, FWD_B}, {28'd0, d.fwd});
`endif
        check("stall_cnt", 32'(STALL_CNT), 32'(d.sc));
        check("flush_cnt", 32'(FLUSH_CNT), 32'(d.fc));
        check("stall_err", 32'(STALL_ERR), 32'(d.err));

        @(posedge CLK);
        if (RESET) begin
            m_state = 2'd0; m_sc = '0; m_fc = '0; m_run = 0; m_err = 1'b0;
        end else begin
            if (tk && m_fc != {CNT_W{1'b1}}) m_fc = m_fc + 1'b1;
            if (st) begin
                if (m_sc != {CNT_W{1'b1}}) m_sc = m_sc + 1'b1;
                m_run = m_run + 1;
                if (m_run >= MAX_STALL) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
            m_state = tk ? 2'd2 : (hz ? 2'd1 : 2'd0);
        end
        @(negedge CLK);
    endtask

    task automatic clr_in();
        ID_RS1 = '0; ID_RS2 = '0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
        EX_RD = '0; EX_REGWRITE = 1'b0; EX_MEMREAD = 1'b0;
        MEM_RD = '0; MEM_REGWRITE = 1'b0; WB_RD = '0; WB_REGWRITE = 1'b0;
        BRANCH_TAKEN = 1'b0;
`ifdef FORWARDING_EN
        EX_RS1 = '0; EX_RS2 = '0;
`endif
    endtask

    task automatic do_reset();
        clr_in();
        RESET = 1'b1;
        cycle();
        cycle();
        RESET = 1'b0;
    endtask

    initial begin
        clr_in();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        m_state = 2'd0; m_sc = '0; m_fc = '0; m_run = 0; m_err = 1'b0;

        // Reset holds the pipeline and flushes everything
        cycle();
        check("rst_pc_write", 32'(PC_WRITE), 32'd0);
        check("rst_exmem_flush", 32'(EXMEM_FLUSH), 32'd1);
        cycle();
        RESET = 1'b0;
        cycle();
        check("post_rst_pc_write", 32'(PC_WRITE), 32'd1);
        check("post_rst_stall_cnt", 32'(STALL_CNT), 32'd0);

`ifndef FORWARDING_EN
        // RAW on EX then MEM: two stall cycles
        do_reset();
        ID_RS1 = 5'd5; ID_USES_RS1 = 1'b1; EX_RD = 5'd5; EX_REGWRITE = 1'b1;
        cycle();
        EX_REGWRITE = 1'b0; EX_RD = 5'd0; MEM_RD = 5'd5; MEM_REGWRITE = 1'b1;
        cycle();
        MEM_REGWRITE = 1'b0; MEM_RD = 5'd0;
        cycle();
        check("raw_stall_cnt", 32'(STALL_CNT), 32'd2);

        // Writeback-stage writer is bypassed through the register file
        WB_RD = 5'd5; WB_REGWRITE = 1'b1;
        cycle();
        check("wb_bypass_pc_write", 32'(PC_WRITE), 32'd1);
        clr_in();

        // x0 never hazards
        ID_USES_RS1 = 1'b1; ID_RS1 = 5'd0; EX_RD = 5'd0; EX_REGWRITE = 1'b1;
        cycle();
        check("x0_pc_write", 32'(PC_WRITE), 32'd1);
        clr_in();
`endif

        // Branch beats a simultaneous hazard; a branch seen in FLUSH is ignored
        do_reset();
        ID_RS2 = 5'd3; ID_USES_RS2 = 1'b1; EX_RD = 5'd3; EX_REGWRITE = 1'b1; EX_MEMREAD = 1'b1;
        BRANCH_TAKEN = 1'b1;
        #1;
        check("br_haz_bubble", 32'(IDEX_BUBBLE), 32'd0);
        check("br_haz_ifid_flush", 32'(IFID_FLUSH), 32'd1);
        cycle();
        clr_in();
        BRANCH_TAKEN = 1'b1;
        cycle();
        BRANCH_TAKEN = 1'b0;
        cycle();
        check("br_flush_cnt", 32'(FLUSH_CNT), 32'd1);
        check("br_stall_cnt", 32'(STALL_CNT), 32'd0);

        // Watchdog trips on the MAX_STALL-th consecutive stall and is sticky
        do_reset();
        ID_RS1 = 5'd4; ID_USES_RS1 = 1'b1; EX_RD = 5'd4; EX_REGWRITE = 1'b1; EX_MEMREAD = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("wd_before", 32'(STALL_ERR), 32'd0);
        cycle();
        check("wd_trip", 32'(STALL_ERR), 32'd1);
        clr_in();
        cycle();
        cycle();
        check("wd_sticky", 32'(STALL_ERR), 32'd1);

        // Counters saturate instead of wrapping
        ID_RS1 = 5'd4; ID_USES_RS1 = 1'b1; EX_RD = 5'd4; EX_REGWRITE = 1'b1; EX_MEMREAD = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("stall_sat", 32'(STALL_CNT), 32'd15);
        clr_in();
        BRANCH_TAKEN = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        check("flush_sat", 32'(FLUSH_CNT), 32'd15);

        // Reset wins over a branch and a hazard
        RESET = 1'b1; BRANCH_TAKEN = 1'b1;
        ID_RS1 = 5'd4; ID_USES_RS1 = 1'b1; EX_RD = 5'd4; EX_REGWRITE = 1'b1; EX_MEMREAD = 1'b1;
        #1;
        check("rst_pri_pc_write", 32'(PC_WRITE), 32'd0);
        check("rst_pri_bubble", 32'(IDEX_BUBBLE), 32'd0);
        cycle();
        RESET = 1'b0;
        clr_in();
        cycle();
        check("rst_pri_flush_cnt", 32'(FLUSH_CNT), 32'd0);
        check("rst_pri_err", 32'(STALL_ERR), 32'd0);

`ifdef FORWARDING_EN
        do_reset();
        EX_RS1 = 5'd7; MEM_RD = 5'd7; MEM_REGWRITE = 1'b1; WB_RD = 5'd7; WB_REGWRITE = 1'b1;
        #1;
        check("fwd_a_mem_pri", 32'(FWD_A), 32'd2);
        cycle();
        clr_in();
        EX_MEMREAD = 1'b1; EX_REGWRITE = 1'b1; EX_RD = 5'd9; ID_RS2 = 5'd9; ID_USES_RS2 = 1'b1;
        cycle();
        EX_MEMREAD = 1'b0; EX_REGWRITE = 1'b0; EX_RD = 5'd0; MEM_RD = 5'd9; MEM_REGWRITE = 1'b1;
        cycle();
        check("load_use_stall_cnt", 32'(STALL_CNT), 32'd1);
        clr_in();
`endif

        // Random traffic over a small register set to make collisions common
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ID_RS1       = 5'($urandom_range(0, 3));
            ID_RS2       = 5'($urandom_range(0, 3));
            ID_USES_RS1  = 1'($urandom_range(0, 1));
            ID_USES_RS2  = 1'($urandom_range(0, 1));
            EX_RD        = 5'($urandom_range(0, 3));
            EX_REGWRITE  = 1'($urandom_range(0, 1));
            EX_MEMREAD   = 1'($urandom_range(0, 1));
            MEM_RD       = 5'($urandom_range(0, 3));
            MEM_REGWRITE = 1'($urandom_range(0, 1));
            WB_RD        = 5'($urandom_range(0, 3));
            WB_REGWRITE  = 1'($urandom_range(0, 1));
            BRANCH_TAKEN = ($urandom_range(0, 4) == 0);
            RESET        = ($urandom_range(0, 60) == 0);
`ifdef FORWARDING_EN
            EX_RS1       = 5'($urandom_range(0, 3));
            EX_RS2       = 5'($urandom_range(0, 3));
`endif
            cycle();
        end
        RESET = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
